dino_sfx_player: RTL and testbench
==================================

Name: dino_sfx_player

Overview:
- Reader and streamer for a synchronous-read sound-effect sample ROM, such as the dino jump sound.
- On a trigger it walks ROM addresses 0..SAMPLE_LEN-1, absorbing the ROM's one-cycle read latency.
- It presents each 16-bit sample on a valid/ready stream toward the audio codec output path.
- Sits between game logic (trigger) and the audio core's sample FIFO.

Parameters:
- ADDR_WIDTH, 13, ROM address width; must match the attached ROM.
- DATA_WIDTH, 16, sample width.
- SAMPLE_LEN, 5000, number of samples played; legal range 1..2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- play  in  1  level-sampled trigger; starts or retriggers playback.
- stop  in  1  aborts playback; has priority over play.
- rom_address  out  ADDR_WIDTH  address to the sample ROM; registered output.
- rom_readdata  in  DATA_WIDTH  ROM data; valid the cycle after the ROM's clock edge samples rom_address.
- sample_data  out  DATA_WIDTH  sample to the codec stream.
- sample_valid  out  1  sample_data is valid.
- sample_ready  in  1  sink accepts sample_data this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last sample is accepted.

Behaviour:
- Reset (async, reset_n low): state IDLE. rom_address=0, sample_data=0, sample_valid=0, busy=0, done=0, retrigger flag=0.
- FSM states: IDLE, FETCH, LOAD, PRESENT.
- IDLE: on an edge with play=1 and stop=0: rom_address<=0, go to FETCH.
- FETCH: rom_address is stable; the ROM captures it at this edge. Go to LOAD.
- LOAD: rom_readdata is valid. sample_data<=rom_readdata, sample_valid<=1, go to PRESENT.
- PRESENT: hold sample_data and sample_valid until an edge with sample_ready=1 (handshake).
- On a PRESENT handshake, with clr = (retrigger flag set):
  - If clr: rom_address<=0, clear flag, go to FETCH.
  - Else if rom_address==SAMPLE_LEN-1: go to IDLE, done<=1 for one cycle, sample_valid<=0.
  - Else: rom_address<=rom_address+1, sample_valid<=0, go to FETCH.
- Latency: play sampled at edge E0 -> sample_valid high after edge E2, with sample_data=ROM[0].
- Throughput with sample_ready tied high: one sample per 3 clocks.
- rom_address never exceeds SAMPLE_LEN-1. No wrap-around when SAMPLE_LEN=2^ADDR_WIDTH: the last address is all-ones and playback terminates there.
- play=1 while busy (FETCH/LOAD/PRESENT): set the retrigger flag. It takes effect at the next PRESENT handshake, so the current sample is still delivered.
- stop=1 in any state: next edge goes to IDLE. sample_valid<=0, retrigger flag cleared, no done pulse, rom_address<=0.
- stop and play both high: stop wins; the block stays or goes IDLE.
- done and play in the same cycle: play is sampled in IDLE on the following edge, so a new playback starts normally.
- sample_data is unchanged while sample_valid=0 except when loaded in LOAD.
- The stream never changes sample_data while sample_valid=1 and sample_ready=0.

Optional Feature:
- Macro: DINO_SFX_LOOP_EN.
- When defined: on the last-sample handshake, if play=1 at that edge, restart at address 0 (go to FETCH) with no done pulse and busy held high. Holding play gives continuous looping.
- When undefined: the last-sample handshake always ends in IDLE with a done pulse, regardless of play.

Test Plan:
- ROM preloaded with ROM[i]=i+0x100, SAMPLE_LEN=8, sample_ready=1, play pulse 1 cycle -> 8 samples 0x100..0x107 in order, one every 3 clocks. First sample_valid 2 edges after play sampled. done pulses once, then busy=0.
- Same setup, sample_ready held low 10 cycles on sample 3 -> sample_data stays 0x103 with sample_valid=1 throughout; no address advance; the sequence resumes intact.
- play pulse re-asserted while presenting sample 4 -> sample 0x104 accepted, then next sample is 0x100; full 8 samples follow; exactly one done.
- stop asserted in LOAD of sample 2 -> next cycle sample_valid=0, busy=0, rom_address=0, no done. A following play restarts at 0x100.
- reset_n asserted low mid-PRESENT (asynchronously, between edges) -> all outputs immediately at reset values. After release with no play, the block stays IDLE.
- With DINO_SFX_LOOP_EN, play held high -> after 0x107 the next sample is 0x100 with no done. Drop play -> the sequence ends after 0x107 with a done pulse.

Source files
------------

// File: rtl/dino_sfx_player.sv
// Streams a sound-effect sample ROM (synchronous read) onto a valid/ready sample stream.
// Optional build macro DINO_SFX_LOOP_EN: holding play across the last sample loops playback.
module dino_sfx_player #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SAMPLE_LEN = 5000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  play,
  input  logic                  stop,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_readdata,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(SAMPLE_LEN - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StPresent} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    retrig_q, retrig_d;
  logic                    play_req;

`ifdef DINO_SFX_LOOP_EN
  // A held play means "keep looping", so only a fresh press may restart mid-sample.
  logic play_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      play_q <= 1'b0;
    end else begin
      play_q <= play;
    end
  end

  assign play_req = play & ~play_q;
`else
  assign play_req = play;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    retrig_d = retrig_q;

    if (stop) begin
      state_d  = StIdle;
      addr_d   = '0;
      valid_d  = 1'b0;
      retrig_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (play) begin
            addr_d  = '0;
            state_d = StFetch;
          end
        end
        // ROM samples rom_address at the edge leaving this state.
        StFetch: begin
          state_d = StLoad;
          if (play_req) retrig_d = 1'b1;
        end
        StLoad: begin
          data_d  = rom_readdata;
          valid_d = 1'b1;
          state_d = StPresent;
          if (play_req) retrig_d = 1'b1;
        end
        StPresent: begin
          if (play_req) retrig_d = 1'b1;
          if (sample_ready) begin
            valid_d = 1'b0;
            if (retrig_q) begin
              addr_d   = '0;
              retrig_d = 1'b0;
              state_d  = StFetch;
            end else if (addr_q == LastAddr) begin
`ifdef DINO_SFX_LOOP_EN
              retrig_d = 1'b0;
              if (play) begin
                addr_d  = '0;
                state_d = StFetch;
              end else begin
                state_d = StIdle;
                done_d  = 1'b1;
              end
`else
              retrig_d = 1'b0;
              state_d  = StIdle;
              done_d   = 1'b1;
`endif
            end else begin
              addr_d  = addr_q + ADDR_WIDTH'(1);
              state_d = StFetch;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      retrig_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      retrig_q <= retrig_d;
    end
  end

  assign rom_address  = addr_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign done         = done_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_dino_sfx_player.sv
// Directed bench for dino_sfx_player: 8-sample ROM filled with i+0x100, 3-bit address space.
module tb_dino_sfx_player;

  localparam int AW  = 3;
  localparam int DW  = 16;
  localparam int LEN = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          play;
  logic          stop;
  logic          sample_ready;
  logic          sample_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_readdata;
  logic [DW-1:0] sample_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          done_cnt;

  typedef struct {
    logic        play;
    logic        stop;
    logic        ready;
    logic        busy;
    logic        valid;
    logic        done;
    logic [15:0] data;
    int          addr;
  } vec_t;

  vec_t vecs[28];

  dino_sfx_player #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .SAMPLE_LEN(LEN)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .play        (play),
    .stop        (stop),
    .rom_address (rom_address),
    .rom_readdata(rom_readdata),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read ROM model: ROM[i] = i + 0x100.
  always @(posedge clk) rom_readdata <= 16'h0100 + {13'd0, rom_address};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int i, input logic p, input logic s, input logic r, input logic b,
                         input logic v, input logic d, input logic [15:0] dat, input int a);
    vecs[i].play  = p;
    vecs[i].stop  = s;
    vecs[i].ready = r;
    vecs[i].busy  = b;
    vecs[i].valid = v;
    vecs[i].done  = d;
    vecs[i].data  = dat;
    vecs[i].addr  = a;
  endtask

  // Plays from IDLE and collects accepted samples until done. stall_k: sample index to hold
  // ready low on for 10 cycles; retrig_k: re-press play in the fetch of that sample index;
  // hold_n: keep play high until this many samples were accepted.
  task automatic run(input string tag, input int stall_k, input int retrig_k, input int hold_n);
    int stall_left = 10;
    bit retrigged  = 1'b0;
    bit fin        = 1'b0;
    got_q.delete();
    done_cnt     = 0;
    stop         = 1'b0;
    sample_ready = 1'b1;
    play         = 1'b1;
    step();
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (done) done_cnt++;
      if (done && !busy) begin
        fin = 1'b1;
      end else begin
        sample_ready = 1'b1;
        if (stall_k >= 0 && sample_valid && sample_data == 16'h0100 + 16'(stall_k) &&
            stall_left > 0) begin
          sample_ready = 1'b0;
          stall_left--;
          chk({tag, " stall addr"}, 32'(rom_address), stall_k);
        end
        play = (got_q.size() < hold_n);
        if (retrig_k >= 0 && !retrigged && got_q.size() == retrig_k && busy && !sample_valid) begin
          play      = 1'b1;
          retrigged = 1'b1;
        end
        if (sample_valid && sample_ready) got_q.push_back(sample_data);
        step();
      end
    end
    play         = 1'b0;
    sample_ready = 1'b1;
    chk({tag, " finished"}, 32'(fin), 1);
    if (stall_k >= 0) chk({tag, " stall cycles left"}, stall_left, 0);
    chk({tag, " done pulses"}, done_cnt, 1);
    chk({tag, " sample count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s sample %0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, " no extra done"}, 32'(done), 0);
    end
    chk({tag, " idle after"}, 32'(busy), 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    play         = 1'b0;
    stop         = 1'b0;
    sample_ready = 1'b1;
    #12;
    chk("reset addr", 32'(rom_address), 0);
    chk("reset data", 32'(sample_data), 0);
    chk("reset valid", 32'(sample_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    reset_n = 1'b1;

    // Basic playback with ready tied high, framed by stop-vs-play and done-vs-play corners.
    set_row(0, 1, 1, 1, 0, 0, 0, 16'h0000, 0);
    set_row(1, 1, 0, 1, 1, 0, 0, 16'h0000, 0);
    for (int k = 0; k < LEN; k++) begin
      set_row(2 + 3 * k, 0, 0, 1, 1, 0, 0, (k == 0) ? 16'h0000 : 16'h00ff + 16'(k), k);
      set_row(3 + 3 * k, 0, 0, 1, 1, 1, 0, 16'h0100 + 16'(k), k);
      if (k < LEN - 1) set_row(4 + 3 * k, 0, 0, 1, 1, 0, 0, 16'h0100 + 16'(k), k + 1);
      else             set_row(4 + 3 * k, 0, 0, 1, 0, 0, 1, 16'h0100 + 16'(k), k);
    end
    set_row(26, 1, 0, 1, 1, 0, 0, 16'h0107, 0);
    set_row(27, 0, 1, 1, 0, 0, 0, 16'h0107, 0);
    for (int i = 0; i < 28; i++) begin
      play         = vecs[i].play;
      stop         = vecs[i].stop;
      sample_ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d valid", i), 32'(sample_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("vec%0d data", i), 32'(sample_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d addr", i), 32'(rom_address), vecs[i].addr);
    end
    play = 1'b0;
    stop = 1'b0;

    // Backpressure on sample 3.
    exp_q.delete();
    for (int i = 0; i < LEN; i++) exp_q.push_back(16'h0100 + 16'(i));
    run("stall", 3, -1, 0);

    // Retrigger during sample 4: 0x104 still delivered, then a full replay.
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h0100 + 16'(i));
    for (int i = 0; i < LEN; i++) exp_q.push_back(16'h0100 + 16'(i));
    run("retrig", -1, 4, 0);

    // Stop in the load of sample 2.
    play = 1'b1;
    step();
    play = 1'b0;
    repeat (7) step();
    chk("stop pre addr", 32'(rom_address), 2);
    chk("stop pre busy", 32'(busy), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop valid", 32'(sample_valid), 0);
    chk("stop busy", 32'(busy), 0);
    chk("stop addr", 32'(rom_address), 0);
    chk("stop done", 32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stop no done", 32'(done), 0);
    end
    exp_q.delete();
    for (int i = 0; i < LEN; i++) exp_q.push_back(16'h0100 + 16'(i));
    run("after stop", -1, -1, 0);

    // Asynchronous reset while presenting sample 0.
    play = 1'b1;
    step();
    play         = 1'b0;
    sample_ready = 1'b0;
    step();
    step();
    chk("pre reset valid", 32'(sample_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset addr", 32'(rom_address), 0);
    chk("async reset data", 32'(sample_data), 0);
    chk("async reset valid", 32'(sample_valid), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset done", 32'(done), 0);
    #2;
    reset_n      = 1'b1;
    sample_ready = 1'b1;
    repeat (5) step();
    chk("post reset busy", 32'(busy), 0);
    chk("post reset valid", 32'(sample_valid), 0);
    chk("post reset addr", 32'(rom_address), 0);

`ifdef DINO_SFX_LOOP_EN
    // Held play loops with no done; releasing it ends after the next 0x107.
    exp_q.delete();
    for (int i = 0; i < 2 * LEN; i++) exp_q.push_back(16'h0100 + 16'(i % LEN));
    run("loop", -1, -1, 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
